button_conditioner: RTL

Input conditioning stage between the raw button/switch levels and `calculator`. Synchronises every button bit, debounces each one independently, and converts presses into single-cycle, one-hot `calc_pkg::buttons_t` pulses with one-key rollover. An optional auto-repeat feature can be compiled in. Runs in the calculator clock domain and drives `calculator.buttons_i` directly.

---
 rtl/button_conditioner.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner (with package calc_pkg)
//  Description : Synchronises, debounces and converts raw button levels into
//                single-cycle one-hot calc_pkg::buttons_t pulses with
//                one-key rollover. Auto-repeat is compiled in when the macro
//                BUTTON_CONDITIONER_REPEAT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================

package calc_pkg;
  localparam int NUM_BUTTONS = 23;

  // Declared in priority order: the MSB (clear) is the highest priority key,
  // so the priority encoder simply picks the highest set bit.
  typedef struct packed {
    logic clear;
    logic mem_recall;
    logic mem_clear;
    logic mem_sub;
    logic mem_add;
    logic op_percent;
    logic op_sqrt;
    logic op_div;
    logic op_mul;
    logic op_sub;
    logic op_add;
    logic op_eq;
    logic dot;
    logic num_1;
    logic num_2;
    logic num_3;
    logic num_4;
    logic num_5;
    logic num_6;
    logic num_7;
    logic num_8;
    logic num_9;
    logic num_0;
  } buttons_t;
endpackage

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [calc_pkg::NUM_BUTTONS-1:0] buttons_raw_i,
  output calc_pkg::buttons_t               buttons_o,
  output logic                             held_o
);

  localparam int N     = calc_pkg::NUM_BUTTONS;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IDX_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } state_t;

  logic [N-1:0]     sync_meta;
  logic [N-1:0]     sync;
  logic [N-1:0]     stable;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] active;
  logic [IDX_W-1:0] active_next;
  logic [N-1:0]     pulse_next;
  logic             rep_fire;
  state_t           state;
  state_t           state_next;

  // Two-flop synchroniser on every raw button bit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= buttons_raw_i;
      sync      <= sync_meta;
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_debounce
      logic [CNT_W-1:0] cnt;
      logic             level;

      // Accept a new level only after it differs for DEBOUNCE_CYCLES edges in a row
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt   <= '0;
          level <= 1'b0;
        end else if (sync[i] == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt   <= '0;
          level <= ~level;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      assign stable[i] = level;
    end
  endgenerate

  // Priority encoder: highest set bit wins
  always_comb begin
    top_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (stable[j]) top_idx = IDX_W'(j);
    end
  end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_SAT     = '1;

  logic [REP_W-1:0] rep_cnt;
  logic             rep_first;
  logic             rep_live;

  // rep_cnt counts cycles since the last pulse; the first gap is the longer delay
  assign rep_fire = (state == HELD) && rep_live && stable[active] &&
                    (rep_cnt == (rep_first ? DELAY_LAST : PERIOD_LAST));

  // Repeat timer: armed on PRESS, killed for good once the active key drops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
      rep_live  <= 1'b0;
    end else if (state == PRESS) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
      rep_live  <= 1'b1;
    end else if (state == HELD) begin
      if (!stable[active]) rep_live <= 1'b0;
      if (rep_fire) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else if (rep_live && (rep_cnt != REP_SAT)) begin
        rep_cnt <= rep_cnt + REP_W'(1);
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Next-state and pulse decode for the press/held FSM
  always_comb begin
    state_next  = state;
    active_next = active;
    pulse_next  = '0;
    case (state)
      IDLE: begin
        if (|stable) begin
          active_next = top_idx;
          state_next  = PRESS;
        end
      end
      PRESS: begin
        pulse_next[active] = 1'b1;
        state_next         = HELD;
      end
      HELD: begin
        if (rep_fire) pulse_next[active] = 1'b1;
        if (~|stable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, captured key and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      active    <= '0;
      buttons_o <= '0;
      held_o    <= 1'b0;
    end else begin
      state     <= state_next;
      active    <= active_next;
      buttons_o <= calc_pkg::buttons_t'(pulse_next);
      held_o    <= (state == HELD);
    end
  end

endmodule
`default_nettype wire
